mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 149 ++++++++++++++
 tb/tb_mem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Unified instruction/data memory responder for a multi-cycle core.
// Accepts one request at a time, waits WAIT_CYCLES, then pulses ready.
//
// Ports:
//   clk    - rising-edge clock for all state
//   reset  - synchronous active-high reset (memory contents are kept)
//   req    - request valid, sampled only while idle
//   we     - 1 = write, 0 = read
//   addr   - byte address; must be word aligned and inside the memory
//   wdata  - store data
//   wstrb  - byte-lane write enables, bit i covers wdata[8i+7:8i]
//   rdata  - read data (0 for writes and errors), held until next access
//   ready  - one-cycle response strobe
//   err    - response is an error, meaningful while ready=1
//   busy   - high whenever a request is in flight
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH30 = 30'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_n;

    logic [3:0] cnt;
    logic [3:0] cnt_n;

    // accept: request taken this edge; fire: access performed this edge
    logic accept;
    logic fire;

    logic          we_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          bad_q;

    logic bad_in;

    logic [31:0] mem [DEPTH_WORDS];

    // Misaligned or past-the-end addresses are rejected, never aliased.
    assign bad_in = (addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH30);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        fire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    cnt_n   = WAIT_LD;
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    fire    = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Request fields are frozen at acceptance so later bus changes
    // cannot leak into the access.
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            we_q    <= we;
            idx_q   <= addr[AW+1:2];
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            bad_q   <= bad_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= 32'd0;
            err   <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else if (fire) begin
            err <= bad_q;
            if (bad_q || we_q) begin
                rdata <= 32'd0;
            end else begin
                rdata <= mem[idx_q];
            end
        end
    end

    // Reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && fire && we_q && !bad_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with three wait settings.
// Instance 0: WAIT=1, instance 1: WAIT=0, instance 2: WAIT=3.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset [3];
    logic        req   [3];
    logic        we    [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        err   [3];
    logic        busy  [3];

    int total = 0;
    int bad   = 0;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) d0 (
        .clk(clk), .reset(reset[0]), .req(req[0]), .we(we[0]),
        .addr(addr[0]), .wdata(wdata[0]), .wstrb(wstrb[0]),
        .rdata(rdata[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0])
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) d1 (
        .clk(clk), .reset(reset[1]), .req(req[1]), .we(we[1]),
        .addr(addr[1]), .wdata(wdata[1]), .wstrb(wstrb[1]),
        .rdata(rdata[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1])
    );

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(3)) d2 (
        .clk(clk), .reset(reset[2]), .req(req[2]), .we(we[2]),
        .addr(addr[2]), .wdata(wdata[2]), .wstrb(wstrb[2]),
        .rdata(rdata[2]), .ready(ready[2]), .err(err[2]), .busy(busy[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge with the DUT idle.
    task automatic txn(input int i, input string tag, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int lat,
                       input logic [31:0] exp_rd, input logic exp_e);
        int n;
        req[i]   = 1'b1;
        we[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
        wstrb[i] = s;
        @(posedge clk);
        @(negedge clk);
        req[i] = 1'b0;
        n = 0;
        while (ready[i] !== 1'b1 && n < 40) begin
            chk({tag, ".busy"}, 32'(busy[i]), 32'd1);
            @(negedge clk);
            n++;
        end
        chk({tag, ".lat"}, 32'(n), 32'(lat));
        chk({tag, ".busy_resp"}, 32'(busy[i]), 32'd1);
        chk({tag, ".rdata"}, rdata[i], exp_rd);
        chk({tag, ".err"}, 32'(err[i]), 32'(exp_e));
        @(negedge clk);
        chk({tag, ".ready_off"}, 32'(ready[i]), 32'd0);
        chk({tag, ".busy_off"}, 32'(busy[i]), 32'd0);
        chk({tag, ".hold"}, rdata[i], exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            reset[i] = 1'b1;
            req[i]   = 1'b0;
            we[i]    = 1'b0;
            addr[i]  = 32'd0;
            wdata[i] = 32'd0;
            wstrb[i] = 4'd0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst.ready", 32'(ready[i]), 32'd0);
            chk("rst.busy", 32'(busy[i]), 32'd0);
            chk("rst.err", 32'(err[i]), 32'd0);
            chk("rst.rdata", rdata[i], 32'd0);
            reset[i] = 1'b0;
        end
        @(negedge clk);

        // WAIT_CYCLES=1: latency 2 negedges after acceptance
        txn(0, "w10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 32'd0, 1'b0);
        txn(0, "r10", 1'b0, 32'h10, 32'd0, 4'h0, 2, 32'hDEADBEEF, 1'b0);
        txn(0, "w08", 1'b1, 32'h08, 32'h11223344, 4'hF, 2, 32'd0, 1'b0);
        txn(0, "w08s", 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, 2, 32'd0, 1'b0);
        txn(0, "r08", 1'b0, 32'h08, 32'd0, 4'h0, 2, 32'h11BB33DD, 1'b0);
        txn(0, "w00", 1'b1, 32'h00, 32'h12345678, 4'hF, 2, 32'd0, 1'b0);
        txn(0, "r06", 1'b0, 32'h06, 32'd0, 4'h0, 2, 32'd0, 1'b1);
        txn(0, "w400", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 2, 32'd0, 1'b1);
        txn(0, "r00", 1'b0, 32'h00, 32'd0, 4'h0, 2, 32'h12345678, 1'b0);
        txn(0, "wz", 1'b1, 32'h10, 32'h00000000, 4'h0, 2, 32'd0, 1'b0);
        txn(0, "rz", 1'b0, 32'h10, 32'd0, 4'h0, 2, 32'hDEADBEEF, 1'b0);
        txn(0, "w3fc", 1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 2, 32'd0, 1'b0);
        txn(0, "r3fc", 1'b0, 32'h3FC, 32'd0, 4'h0, 2, 32'hA5A5A5A5, 1'b0);
        txn(0, "rhi", 1'b0, 32'h80000010, 32'd0, 4'h0, 2, 32'd0, 1'b1);
        txn(0, "r10b", 1'b0, 32'h10, 32'd0, 4'h0, 2, 32'hDEADBEEF, 1'b0);

        // WAIT_CYCLES=0 with req held high: pulse every 3 cycles
        txn(1, "p04", 1'b1, 32'h04, 32'hCAFEF00D, 4'hF, 1, 32'd0, 1'b0);
        txn(1, "p14", 1'b1, 32'h14, 32'h01010101, 4'hF, 1, 32'd0, 1'b0);
        req[1]  = 1'b1;
        we[1]   = 1'b0;
        addr[1] = 32'h04;
        @(posedge clk);
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            if (n == 0) addr[1] = 32'h14;
            chk($sformatf("stream.ready%0d", n), 32'(ready[1]),
                32'((n % 3) == 1));
            if (n == 1) chk("stream.rd1", rdata[1], 32'hCAFEF00D);
            if (n == 4) chk("stream.rd4", rdata[1], 32'h01010101);
        end
        req[1] = 1'b0;
        @(negedge clk);
        chk("stream.idle", 32'(busy[1]), 32'd0);

        // WAIT_CYCLES=3: reset mid-access and on the access edge
        txn(2, "p0c", 1'b1, 32'h0C, 32'h00001111, 4'hF, 4, 32'd0, 1'b0);
        req[2]   = 1'b1;
        we[2]    = 1'b1;
        addr[2]  = 32'h0C;
        wdata[2] = 32'h0000CAFE;
        wstrb[2] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req[2] = 1'b0;
        chk("mid.busy0", 32'(busy[2]), 32'd1);
        @(negedge clk);
        reset[2] = 1'b1;
        @(negedge clk);
        reset[2] = 1'b0;
        chk("mid.busy", 32'(busy[2]), 32'd0);
        chk("mid.ready", 32'(ready[2]), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("mid.quiet%0d", k), 32'(ready[2]), 32'd0);
        end
        txn(2, "mid.rd", 1'b0, 32'h0C, 32'd0, 4'h0, 4, 32'h00001111, 1'b0);

        req[2] = 1'b1;
        we[2]  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[2] = 1'b0;
        repeat (3) @(negedge clk);
        reset[2] = 1'b1;
        @(negedge clk);
        reset[2] = 1'b0;
        chk("edge.ready", 32'(ready[2]), 32'd0);
        chk("edge.busy", 32'(busy[2]), 32'd0);
        @(negedge clk);
        chk("edge.ready2", 32'(ready[2]), 32'd0);
        txn(2, "edge.rd", 1'b0, 32'h0C, 32'd0, 4'h0, 4, 32'h00001111, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
